softmax_row_driver: RTL and testbench

Sequencer that feeds the `softmax` block one row at a time and collects its results. It reads `row_count` rows of `NUM_LANES` 32-bit integers from the output buffer. For each row it holds the row on the softmax input and pulses `sm_en`, then samples the fixed-point softmax result after a fixed latency. Each result row is written to the result buffer through a valid/ready port. It sits between the systolic array output buffer and the result memory.

---
 rtl/softmax_row_driver.sv | 236 +++++++++++++++++++++++
 tb/tb_softmax_row_driver.sv | 383 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/softmax_row_driver.sv
// softmax_row_driver: sequences rows from the output buffer through the
// softmax block and writes each result row to the result buffer.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   start           one-cycle job request (sampled in IDLE only)
//   row_count       rows in the job        (latched with start)
//   src_base        first read address     (latched with start)
//   dst_base        first write address    (latched with start)
//   busy, done      job status / end-of-job pulse
//   rd_en, rd_addr  output-buffer read strobe and address
//   rd_data         row data, valid the cycle after rd_en
//   sm_en, sm_xi    softmax start pulse and row presented on Xi
//   sm_out          softmax result
//   wr_valid, wr_ready, wr_addr, wr_data
//                   result-buffer write port (valid/ready)

`ifndef ARRAYWIDTH
`define ARRAYWIDTH 4
`endif

module softmax_row_driver #(
   parameter int NUM_LANES  = `ARRAYWIDTH,
   parameter int DATA_W     = 32,
   parameter int ADDR_W     = 8,
   parameter int SM_LATENCY = 24
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        start,
   input  logic [ADDR_W-1:0]           row_count,
   input  logic [ADDR_W-1:0]           src_base,
   input  logic [ADDR_W-1:0]           dst_base,
   output logic                        busy,
   output logic                        done,
   output logic                        rd_en,
   output logic [ADDR_W-1:0]           rd_addr,
   input  logic [NUM_LANES*DATA_W-1:0] rd_data,
   output logic                        sm_en,
   output logic [NUM_LANES*DATA_W-1:0] sm_xi,
   input  logic [NUM_LANES*DATA_W-1:0] sm_out,
   output logic                        wr_valid,
   input  logic                        wr_ready,
   output logic [ADDR_W-1:0]           wr_addr,
   output logic [NUM_LANES*DATA_W-1:0] wr_data
);

   localparam int ROW_W = NUM_LANES * DATA_W;
   // Counter holds SM_LATENCY-1 down to 0; SM_LATENCY >= 2 keeps CNT_W >= 1.
   localparam int CNT_W = $clog2(SM_LATENCY);
   localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(SM_LATENCY - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_READ,
      S_WAIT_RD,
      S_LAUNCH,
      S_WAIT_SM,
      S_WRITE,
      S_DONE
   } state_t;

   state_t              state_q;
   state_t              state_d;

   logic [ADDR_W-1:0]   row_idx_q;
   logic [ADDR_W-1:0]   row_cnt_q;
   logic [ADDR_W-1:0]   src_q;
   logic [ADDR_W-1:0]   dst_q;
   logic [CNT_W-1:0]    lat_q;
   logic [ROW_W-1:0]    xi_q;
   logic [ROW_W-1:0]    res_q;

   logic [ADDR_W-1:0]   idx_next;

   logic                ld_job;
   logic                ld_xi;
   logic                ld_lat;
   logic                dec_lat;
   logic                ld_res;
   logic                inc_row;

   assign idx_next = row_idx_q + ADDR_W'(1);

   // Both registers hold their value outside the single load cycle, so
   // Xi stays stable while softmax is idle and the write payload stays
   // stable under backpressure.
   assign sm_xi   = xi_q;
   assign wr_data = res_q;

   // ------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // ------------------------------------------------------------------
   // Next state and outputs
   // ------------------------------------------------------------------
   always_comb begin
      state_d  = state_q;
      busy     = (state_q != S_IDLE);
      done     = 1'b0;
      rd_en    = 1'b0;
      rd_addr  = '0;
      sm_en    = 1'b0;
      wr_valid = 1'b0;
      wr_addr  = '0;
      ld_job   = 1'b0;
      ld_xi    = 1'b0;
      ld_lat   = 1'b0;
      dec_lat  = 1'b0;
      ld_res   = 1'b0;
      inc_row  = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               ld_job = 1'b1;
               if (row_count == '0) begin
                  state_d = S_DONE;
               end else begin
                  state_d = S_READ;
               end
            end
         end

         S_READ: begin
            rd_en   = 1'b1;
            rd_addr = src_q + row_idx_q;
            state_d = S_WAIT_RD;
         end

         S_WAIT_RD: begin
            ld_xi   = 1'b1;
            state_d = S_LAUNCH;
         end

         S_LAUNCH: begin
            sm_en   = 1'b1;
            ld_lat  = 1'b1;
            state_d = S_WAIT_SM;
         end

         // Counter reaches 0 in the cycle SM_LATENCY after LAUNCH,
         // which is the cycle sm_out carries the result.
         S_WAIT_SM: begin
            if (lat_q == '0) begin
               ld_res  = 1'b1;
               state_d = S_WRITE;
            end else begin
               dec_lat = 1'b1;
            end
         end

         S_WRITE: begin
            wr_valid = 1'b1;
            wr_addr  = dst_q + row_idx_q;
            if (wr_ready) begin
               inc_row = 1'b1;
               if (idx_next == row_cnt_q) begin
                  state_d = S_DONE;
               end else begin
                  state_d = S_READ;
               end
            end
         end

         S_DONE: begin
            done    = 1'b1;
            state_d = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // Job parameters and row index
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         row_cnt_q <= '0;
         src_q     <= '0;
         dst_q     <= '0;
         row_idx_q <= '0;
      end else if (ld_job) begin
         row_cnt_q <= row_count;
         src_q     <= src_base;
         dst_q     <= dst_base;
         row_idx_q <= '0;
      end else if (inc_row) begin
         row_idx_q <= idx_next;
      end
   end

   // ------------------------------------------------------------------
   // Softmax latency counter
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lat_q <= '0;
      end else if (ld_lat) begin
         lat_q <= LAT_LOAD;
      end else if (dec_lat) begin
         lat_q <= lat_q - CNT_W'(1);
      end
   end

   // ------------------------------------------------------------------
   // Row data registers
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         xi_q <= '0;
      end else if (ld_xi) begin
         xi_q <= rd_data;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         res_q <= '0;
      end else if (ld_res) begin
         res_q <= sm_out;
      end
   end

endmodule

// File: tb/tb_softmax_row_driver.sv
// tb_softmax_row_driver: scoreboard bench for softmax_row_driver with a
// behavioural output buffer and a fixed-latency softmax stand-in.

module tb_softmax_row_driver;

   localparam int NL  = 4;
   localparam int DW  = 32;
   localparam int AW  = 8;
   localparam int LAT = 24;
   localparam int RW  = NL * DW;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic [AW-1:0] row_count;
   logic [AW-1:0] src_base;
   logic [AW-1:0] dst_base;
   logic          busy;
   logic          done;
   logic          rd_en;
   logic [AW-1:0] rd_addr;
   logic [RW-1:0] rd_data;
   logic          sm_en;
   logic [RW-1:0] sm_xi;
   logic [RW-1:0] sm_out;
   logic          wr_valid;
   logic          wr_ready;
   logic [AW-1:0] wr_addr;
   logic [RW-1:0] wr_data;

   softmax_row_driver #(
      .NUM_LANES (NL),
      .DATA_W    (DW),
      .ADDR_W    (AW),
      .SM_LATENCY(LAT)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .row_count(row_count),
      .src_base (src_base),
      .dst_base (dst_base),
      .busy     (busy),
      .done     (done),
      .rd_en    (rd_en),
      .rd_addr  (rd_addr),
      .rd_data  (rd_data),
      .sm_en    (sm_en),
      .sm_xi    (sm_xi),
      .sm_out   (sm_out),
      .wr_valid (wr_valid),
      .wr_ready (wr_ready),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_cmp = 0;
   int n_bad = 0;

   // scoreboard queues
   logic [AW-1:0] rd_q [$];
   logic [RW-1:0] xi_q [$];
   logic [AW-1:0] wr_q [$];
   logic [RW-1:0] res_q [$];

   // event timestamps
   int rd_cyc [$];
   int sm_cyc [$];
   int wr_cyc [$];
   int done_cnt = 0;
   int done_cyc = -1;

   logic [RW-1:0] mem [256];

   function automatic logic [RW-1:0] rnd_row();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   function automatic int qget(input int q[$], input int i);
      if (q.size() > i) return q[i];
      return -1;
   endfunction

   task automatic chk(input string nm, input logic [RW-1:0] act,
                      input logic [RW-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic chk_i(input string nm, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic fail_evt(input string nm);
      n_cmp++;
      n_bad++;
      $display("FAIL %s: got unexpected event, expected none", nm);
   endtask

   // output buffer: data appears the cycle after rd_en, junk otherwise
   always @(posedge clk) begin
      if (rd_en) rd_data <= mem[rd_addr];
      else       rd_data <= rnd_row();
   end

   // softmax stand-in: result visible exactly LAT cycles after sm_en
   bit            sm_act = 0;
   int            sm_cnt = 0;
   logic [RW-1:0] sm_res;
   always @(posedge clk) begin
      logic [RW-1:0] v;
      v = rnd_row();
      if (rst) begin
         sm_act = 0;
      end else if (sm_act) begin
         sm_cnt--;
         if (sm_cnt == 0) begin
            v      = sm_res;
            sm_act = 0;
         end
      end
      if (!rst && sm_en) begin
         sm_act = 1;
         sm_cnt = LAT - 1;
         sm_res = rnd_row();
         res_q.push_back(sm_res);
      end
      sm_out <= v;
   end

   // monitor
   bit            held = 0;
   logic [AW-1:0] h_addr;
   logic [RW-1:0] h_data;
   always @(negedge clk) begin
      if (rst) begin
         held = 0;
      end else begin
         if (rd_en) begin
            rd_cyc.push_back(cyc);
            if (rd_q.size() == 0) fail_evt("rd_extra");
            else chk_i("rd_addr", int'(rd_addr), int'(rd_q.pop_front()));
         end
         if (sm_en) begin
            sm_cyc.push_back(cyc);
            if (xi_q.size() == 0) fail_evt("sm_extra");
            else chk("sm_xi", sm_xi, xi_q.pop_front());
         end
         if (held && !wr_valid) fail_evt("wr_valid_dropped");
         if (wr_valid) begin
            chk_i("no_issue_in_write", int'(rd_en | sm_en), 0);
            if (held) begin
               chk_i("wr_addr_stable", int'(wr_addr), int'(h_addr));
               chk("wr_data_stable", wr_data, h_data);
            end
            if (wr_ready) begin
               wr_cyc.push_back(cyc);
               held = 0;
               if (wr_q.size() == 0) fail_evt("wr_extra");
               else chk_i("wr_addr", int'(wr_addr), int'(wr_q.pop_front()));
               if (res_q.size() == 0) fail_evt("wr_data_extra");
               else chk("wr_data", wr_data, res_q.pop_front());
            end else begin
               held   = 1;
               h_addr = wr_addr;
               h_data = wr_data;
            end
         end else begin
            held = 0;
         end
         if (done) begin
            done_cnt++;
            done_cyc = cyc;
         end
      end
   end

   int s_cyc;
   int d0;
   int s;
   int n;

   task automatic clr();
      rd_cyc.delete();
      sm_cyc.delete();
      wr_cyc.delete();
   endtask

   task automatic flush();
      rd_q.delete();
      xi_q.delete();
      wr_q.delete();
      res_q.delete();
   endtask

   task automatic start_job(input int cnt, input logic [AW-1:0] src,
                            input logic [AW-1:0] dst);
      logic [AW-1:0] a;
      @(posedge clk); #1;
      for (int i = 0; i < cnt; i++) begin
         a = src + AW'(i);
         rd_q.push_back(a);
         xi_q.push_back(mem[a]);
         wr_q.push_back(dst + AW'(i));
      end
      row_count = AW'(cnt);
      src_base  = src;
      dst_base  = dst;
      start     = 1'b1;
      s_cyc     = cyc;
      @(posedge clk); #1;
      start     = 1'b0;
      row_count = AW'($urandom);
      src_base  = AW'($urandom);
      dst_base  = AW'($urandom);
   endtask

   task automatic wait_done(input int d, input int budget, input bit rnd);
      int k;
      k = 0;
      while (done_cnt == d && k < budget) begin
         @(posedge clk); #1;
         if (rnd) wr_ready = ($urandom_range(0, 3) != 0);
         k++;
      end
      if (done_cnt == d) fail_evt("done_timeout");
      wr_ready = 1'b1;
   endtask

   task automatic chk_empty(input string p);
      chk_i({p, "_rd_left"}, rd_q.size(), 0);
      chk_i({p, "_wr_left"}, wr_q.size(), 0);
      chk_i({p, "_res_left"}, res_q.size(), 0);
   endtask

   task automatic chk_zero(input string p);
      chk_i({p, "_busy"}, int'(busy), 0);
      chk_i({p, "_done"}, int'(done), 0);
      chk_i({p, "_rd_en"}, int'(rd_en), 0);
      chk_i({p, "_sm_en"}, int'(sm_en), 0);
      chk_i({p, "_wr_valid"}, int'(wr_valid), 0);
      chk_i({p, "_rd_addr"}, int'(rd_addr), 0);
      chk_i({p, "_wr_addr"}, int'(wr_addr), 0);
      chk({p, "_sm_xi"}, sm_xi, '0);
      chk({p, "_wr_data"}, wr_data, '0);
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = rnd_row();
      rst       = 1'b1;
      start     = 1'b0;
      row_count = '0;
      src_base  = '0;
      dst_base  = '0;
      wr_ready  = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk_zero("reset");
      @(posedge clk); #1;
      rst = 1'b0;

      // single row
      clr(); d0 = done_cnt;
      start_job(1, 8'h10, 8'h80); s = s_cyc;
      wait_done(d0, 200, 0);
      @(negedge clk);
      chk_i("t1_rd_cyc", qget(rd_cyc, 0), s + 1);
      chk_i("t1_sm_cyc", qget(sm_cyc, 0), s + 3);
      chk_i("t1_wr_cyc", qget(wr_cyc, 0), s + 28);
      chk_i("t1_done_cyc", done_cyc, s + 29);
      chk_i("t1_busy_drop", int'(busy), 0);
      chk_i("t1_done_once", done_cnt - d0, 1);
      chk_empty("t1");

      // three rows, ready held high
      clr(); d0 = done_cnt;
      start_job(3, 8'h10, 8'h80); s = s_cyc;
      wait_done(d0, 400, 0);
      repeat (3) @(negedge clk);
      chk_i("t2_sm_gap1", qget(sm_cyc, 1) - qget(sm_cyc, 0), 28);
      chk_i("t2_sm_gap2", qget(sm_cyc, 2) - qget(sm_cyc, 1), 28);
      chk_i("t2_done_cyc", done_cyc, s + 1 + 3 * 28);
      chk_i("t2_done_once", done_cnt - d0, 1);
      chk_empty("t2");

      // backpressure on row 0
      clr(); d0 = done_cnt;
      wr_ready = 1'b0;
      start_job(2, 8'h50, 8'hA0);
      n = 0;
      while (!wr_valid && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk_i("bp_reach_write", int'(wr_valid), 1);
      repeat (10) @(posedge clk);
      chk_i("bp_no_hs", wr_cyc.size(), 0);
      chk_i("bp_no_rd", rd_cyc.size(), 1);
      chk_i("bp_no_sm", sm_cyc.size(), 1);
      #1 wr_ready = 1'b1;
      wait_done(d0, 200, 0);
      chk_i("bp_rd1_next", qget(rd_cyc, 1), qget(wr_cyc, 0) + 1);
      chk_empty("bp");

      // zero rows
      clr(); d0 = done_cnt;
      start_job(0, 8'h22, 8'h33); s = s_cyc;
      wait_done(d0, 20, 0);
      repeat (5) @(negedge clk);
      chk_i("z_done_cyc", done_cyc, s + 1);
      chk_i("z_no_rd", rd_cyc.size(), 0);
      chk_i("z_no_sm", sm_cyc.size(), 0);
      chk_i("z_no_wr", wr_cyc.size(), 0);

      // address wrap with an ignored mid-job start
      clr(); d0 = done_cnt;
      start_job(2, 8'hFF, 8'h10);
      repeat (8) @(posedge clk);
      #1;
      start     = 1'b1;
      row_count = 8'd5;
      src_base  = 8'h20;
      dst_base  = 8'h60;
      @(posedge clk); #1;
      start = 1'b0;
      wait_done(d0, 300, 0);
      repeat (3) @(negedge clk);
      chk_i("wrap_reads", rd_cyc.size(), 2);
      chk_i("wrap_done_once", done_cnt - d0, 1);
      chk_empty("wrap");

      // reset during row 1 softmax wait
      clr(); d0 = done_cnt;
      start_job(3, 8'h30, 8'h90);
      n = 0;
      while (sm_cyc.size() < 2 && n < 200) begin
         @(posedge clk);
         n++;
      end
      chk_i("rm_reached_row1", sm_cyc.size(), 2);
      repeat (5) @(posedge clk);
      #1 rst = 1'b1;
      #1 chk_zero("rst_mid");
      flush();
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      repeat (4) @(negedge clk);
      chk_i("rm_no_done", done_cnt - d0, 0);
      chk_i("rm_no_more_sm", sm_cyc.size(), 2);
      clr(); d0 = done_cnt;
      start_job(2, 8'h30, 8'h90); s = s_cyc;
      wait_done(d0, 300, 0);
      chk_i("rm_clean_rd0", qget(rd_cyc, 0), s + 1);
      chk_i("rm_clean_done", done_cnt - d0, 1);
      chk_empty("rm");

      // random jobs with random backpressure
      for (int k = 0; k < 4; k++) begin
         clr(); d0 = done_cnt;
         start_job($urandom_range(1, 3), AW'($urandom), AW'($urandom));
         wait_done(d0, 2000, 1);
         repeat (2) @(negedge clk);
         chk_i("rnd_done_once", done_cnt - d0, 1);
         chk_empty("rnd");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
